// File: rtl/ec_pkg.sv
// ec_pkg: shared state encoding, configuration defaults and job config type for the EC engine
package ec_pkg;
  localparam int K_MAX_DEF = 128;
  localparam int K_MIN_DEF = 2;
  localparam int M_MAX_DEF = 128;
  localparam int M_MIN_DEF = 2;
  localparam int K_W_DEF = $clog2(K_MAX_DEF + 1);
  localparam int M_W_DEF = $clog2(M_MAX_DEF + 1);
  localparam int STR_W_DEF = 16;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ENG_RST = 2'd1;
  localparam state_t CALC = 2'd2;
  localparam state_t DONE = 2'd3;
  typedef struct packed {
    logic [K_W_DEF-1:0] k;
    logic [M_W_DEF-1:0] m;
    logic [STR_W_DEF-1:0] num_stripes;
  } cfg_t;
endpackage

// File: rtl/ec_nested_cnt.sv
// ec_nested_cnt: word/column/stripe counter chain with programmable column and stripe limits
module ec_nested_cnt #(
  parameter int PL = 2,
  parameter int WW = 1,
  parameter int CW = 8,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] col_max,
  input  logic [SW-1:0] str_max,
  output logic          word_wrap,
  output logic          col_wrap,
  output logic          last,
  output logic [CW-1:0] col,
  output logic [SW-1:0] stripe
);
  localparam logic [WW-1:0] W_MAX = WW'(PL - 1);
  logic [WW-1:0] word;
  assign word_wrap = en && word == W_MAX;
  assign col_wrap = word_wrap && col == col_max;
  assign last = col_wrap && stripe == str_max;
  // each level advances only when the level below wraps; all levels return to 0 after the final word
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      word <= '0;
      col <= '0;
      stripe <= '0;
    end else if (clr) begin
      word <= '0;
      col <= '0;
      stripe <= '0;
    end else begin
      if (en) word <= word_wrap ? '0 : word + 1'b1;
      if (word_wrap) col <= col_wrap ? '0 : col + 1'b1;
      if (col_wrap) stripe <= last ? '0 : stripe + 1'b1;
    end
endmodule

// File: rtl/ec_eng_seq.sv
// ec_eng_seq: job sequencer stepping the EC engine through words x parity columns x stripes
module ec_eng_seq
  import ec_pkg::*;
#(
  parameter int K_MAX = K_MAX_DEF,
  parameter int K_MIN = K_MIN_DEF,
  parameter int M_MAX = M_MAX_DEF,
  parameter int M_MIN = M_MIN_DEF,
  parameter int PACKET_LENGTH = 2,
  parameter int K_W = $clog2(K_MAX + 1),
  parameter int M_W = $clog2(M_MAX + 1),
  parameter int STR_W = STR_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [K_W-1:0]   k_reg,
  input  logic [M_W-1:0]   m_reg,
  input  logic [STR_W-1:0] num_stripes,
  input  logic             data_in_val,
  input  logic             out_rdy,
  input  logic             bm_col_val,
  output logic             eng_rstn,
  output logic             bm_rd_en,
  output logic             eng_calc_en,
  output logic             eng_data_used,
  output logic             data_in_pop,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [M_W-1:0]   col_idx,
  output logic [STR_W-1:0] stripe_idx
);
  localparam int WW = PACKET_LENGTH > 1 ? $clog2(PACKET_LENGTH) : 1;
  state_t state, nxt;
  logic abort_q, eng_rstn_q, cfg_err_q, legal, kill, go, fire, last;
  logic [M_W-1:0] m_q, m_last;
  logic [STR_W-1:0] n_q, n_last;
  cfg_t cfg_in;
  assign cfg_in = '{k: k_reg, m: m_reg, num_stripes: num_stripes};
  assign legal = cfg_in.k >= K_W'(K_MIN) && cfg_in.k <= K_W'(K_MAX) &&
                 cfg_in.m >= M_W'(M_MIN) && cfg_in.m <= M_W'(M_MAX) && cfg_in.num_stripes != '0;
  assign kill = abort && (state == ENG_RST || state == CALC);
  assign go = state == IDLE && start && !abort;
  assign fire = state == CALC && bm_col_val && data_in_val && out_rdy && !kill;
  assign m_last = m_q - 1'b1;
  assign n_last = n_q - 1'b1;
  // abort wins everywhere it applies; an aborted job pulses the engine reset and then idles
  always_comb
    nxt = kill ? ENG_RST :
          state == IDLE ? (go && legal ? ENG_RST : IDLE) :
          state == ENG_RST ? (abort_q ? IDLE : CALC) :
          state == CALC ? (last ? DONE : CALC) : IDLE;
  // state, abort tracking, registered engine reset and config latch
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      abort_q <= 1'b0;
      eng_rstn_q <= 1'b0;
      cfg_err_q <= 1'b0;
      m_q <= '0;
      n_q <= '0;
    end else begin
      state <= nxt;
      eng_rstn_q <= nxt != ENG_RST;
      abort_q <= kill ? 1'b1 : state == ENG_RST ? 1'b0 : abort_q;
      if (go) begin
        m_q <= m_reg;
        n_q <= num_stripes;
        cfg_err_q <= !legal;
      end
    end
  ec_nested_cnt #(.PL(PACKET_LENGTH), .WW(WW), .CW(M_W), .SW(STR_W)) u_cnt (
    .clk(clk),
    .rstn(rstn),
    .clr(state != CALC || kill),
    .en(fire),
    .col_max(m_last),
    .str_max(n_last),
    .word_wrap(eng_data_used),
    .col_wrap(data_in_pop),
    .last(last),
    .col(col_idx),
    .stripe(stripe_idx)
  );
  assign eng_rstn = eng_rstn_q;
  assign bm_rd_en = state == CALC;
  assign busy = state == ENG_RST || state == CALC;
  assign done = state == DONE;
  assign eng_calc_en = fire;
  assign cfg_err = cfg_err_q;
endmodule
